// File: rtl/comparator_pkg.sv
// Shared types and helpers for the pipelined magnitude comparator.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   cmp_verdict_t  - per-stage running verdict (UNDECIDED / GT / LT)
//   CMP_CNT_W      - width of the optional result statistics counters
//   merge_verdict  - combine an upstream verdict with one chunk compare
//   sat_inc        - saturating increment for the statistics counters
package comparator_pkg;

    typedef enum logic [1:0] {
        UNDECIDED = 2'b00,
        GT        = 2'b01,
        LT        = 2'b10
    } cmp_verdict_t;

    localparam int CMP_CNT_W = 16;
    localparam logic [CMP_CNT_W-1:0] CMP_CNT_MAX = '1;

    // A decided verdict is sticky: more significant chunks always win, so
    // the local chunk only matters while everything above it was equal.
    function automatic cmp_verdict_t merge_verdict(
        input cmp_verdict_t prev,
        input logic         chunk_gt,
        input logic         chunk_lt
    );
        cmp_verdict_t res;
        res = prev;
        if (prev == UNDECIDED) begin
            if (chunk_gt) begin
                res = GT;
            end else if (chunk_lt) begin
                res = LT;
            end
        end
        return res;
    endfunction

    function automatic logic [CMP_CNT_W-1:0] sat_inc(
        input logic [CMP_CNT_W-1:0] val
    );
        return (val == CMP_CNT_MAX) ? val : val + 1'b1;
    endfunction

endpackage

// File: rtl/comparator_pipe_stage.sv
// One pipeline stage: compares a single operand chunk and merges it into the running verdict.
// Latency: 1 cycle (registered outputs).
// Backpressure: global enable adv; when adv=0 the stage holds everything.
//
// Ports:
//   clock, reset            - system clock, async active-high reset
//   adv                     - global advance enable (load when 1, hold when 0)
//   prev_valid/a/b/mode     - transaction from the previous stage (or the input)
//   prev_verdict            - verdict resolved by the more significant chunks
//   valid/a/b/mode/verdict  - registered transaction handed to the next stage
module comparator_pipe_stage
    import comparator_pkg::*;
#(
    parameter int W         = 32,
    parameter int CW        = 8,
    parameter int IDX       = 0,
    parameter bit TOP_CHUNK = 1'b0
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         adv,
    input  logic         prev_valid,
    input  logic [W-1:0] prev_a,
    input  logic [W-1:0] prev_b,
    input  logic         prev_mode,
    input  cmp_verdict_t prev_verdict,
    output logic         valid,
    output logic [W-1:0] a,
    output logic [W-1:0] b,
    output logic         mode,
    output cmp_verdict_t verdict
);

    // Chunk IDX counts from the most significant end of the operands.
    localparam int LSB = W - (IDX + 1) * CW;
    localparam logic [CW-1:0] MSB_MASK = CW'(1) << (CW - 1);

    logic [CW-1:0] cmp_a;
    logic [CW-1:0] cmp_b;
    logic          chunk_gt;
    logic          chunk_lt;
    cmp_verdict_t  verdict_next;

    // Flipping the sign bit of the top chunk maps two's-complement order onto
    // unsigned order; lower chunks carry plain magnitude in either mode.
    always_comb begin
        cmp_a = prev_a[LSB +: CW];
        cmp_b = prev_b[LSB +: CW];
        if (TOP_CHUNK && prev_mode) begin
            cmp_a = cmp_a ^ MSB_MASK;
            cmp_b = cmp_b ^ MSB_MASK;
        end
    end

    assign chunk_gt     = (cmp_a > cmp_b);
    assign chunk_lt     = (cmp_a < cmp_b);
    assign verdict_next = merge_verdict(prev_verdict, chunk_gt, chunk_lt);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid   <= 1'b0;
            a       <= '0;
            b       <= '0;
            mode    <= 1'b0;
            verdict <= UNDECIDED;
        end else if (adv) begin
            valid   <= prev_valid;
            a       <= prev_a;
            b       <= prev_b;
            mode    <= prev_mode;
            verdict <= verdict_next;
        end
    end

endmodule

// File: rtl/comparator_pipe.sv
// Pipelined signed/unsigned magnitude comparator, one operand chunk per stage, MS chunk first.
// Latency: NSTAGES = nrOfBits/chunkBits cycles from accept to out_valid; one result per cycle.
// Backpressure: in_ready = !out_valid | out_ready; a stall freezes the whole pipe (no bubble collapse).
//
// Optional feature: define COMPARATOR_PIPE_STATS_EN to build the three
// saturating result counters; otherwise they read 0 and stats_clear is ignored.
//
// Ports:
//   clock, reset                        - system clock, async active-high reset
//   in_valid/in_ready                   - input handshake for dataA, dataB, twosComplement
//   dataA, dataB                        - operands (nrOfBits wide)
//   twosComplement                      - 1 = signed compare, 0 = unsigned compare
//   out_valid/out_ready                 - result handshake
//   aEqualsB/aGreaterThanB/aLessThanB   - one-hot result while out_valid, else 0
//   stats_clear                         - synchronous clear of the counters
//   cntEqual/cntGreater/cntLess         - per-result transfer counters
module comparator_pipe
    import comparator_pkg::*;
#(
    parameter int nrOfBits  = 32,
    parameter int chunkBits = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [nrOfBits-1:0]  dataA,
    input  logic [nrOfBits-1:0]  dataB,
    input  logic                 twosComplement,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 aEqualsB,
    output logic                 aGreaterThanB,
    output logic                 aLessThanB,
    input  logic                 stats_clear,
    output logic [CMP_CNT_W-1:0] cntEqual,
    output logic [CMP_CNT_W-1:0] cntGreater,
    output logic [CMP_CNT_W-1:0] cntLess
);

    // nrOfBits must be a whole multiple of chunkBits.
    localparam int NSTAGES = nrOfBits / chunkBits;

    // Index 0 is the raw input; index k+1 is the output register of stage k.
    logic                st_valid   [0:NSTAGES];
    logic [nrOfBits-1:0] st_a       [0:NSTAGES];
    logic [nrOfBits-1:0] st_b       [0:NSTAGES];
    logic                st_mode    [0:NSTAGES];
    cmp_verdict_t        st_verdict [0:NSTAGES];

    logic adv;
    logic xfer_out;

    // Single global enable: the pipe only moves when the last stage is
    // empty or being drained, so every stage either shifts or holds together.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    assign st_valid[0]   = in_valid;
    assign st_a[0]       = dataA;
    assign st_b[0]       = dataB;
    assign st_mode[0]    = twosComplement;
    assign st_verdict[0] = UNDECIDED;

    for (genvar k = 0; k < NSTAGES; k++) begin : g_stage
        comparator_pipe_stage #(
            .W         (nrOfBits),
            .CW        (chunkBits),
            .IDX       (k),
            .TOP_CHUNK (k == 0)
        ) u_stage (
            .clock        (clock),
            .reset        (reset),
            .adv          (adv),
            .prev_valid   (st_valid[k]),
            .prev_a       (st_a[k]),
            .prev_b       (st_b[k]),
            .prev_mode    (st_mode[k]),
            .prev_verdict (st_verdict[k]),
            .valid        (st_valid[k+1]),
            .a            (st_a[k+1]),
            .b            (st_b[k+1]),
            .mode         (st_mode[k+1]),
            .verdict      (st_verdict[k+1])
        );
    end

    // Operands and mode leaving the last stage have no further consumer.
    logic unused_tail;
    assign unused_tail = ^{st_a[NSTAGES], st_b[NSTAGES], st_mode[NSTAGES]};

    // Result decode straight off the last stage register, gated by valid so
    // the flags read 0 for bubbles and hold while the consumer stalls.
    assign out_valid     = st_valid[NSTAGES];
    assign aEqualsB      = out_valid && (st_verdict[NSTAGES] == UNDECIDED);
    assign aGreaterThanB = out_valid && (st_verdict[NSTAGES] == GT);
    assign aLessThanB    = out_valid && (st_verdict[NSTAGES] == LT);

    assign xfer_out = out_valid && out_ready;

`ifdef COMPARATOR_PIPE_STATS_EN
    logic [CMP_CNT_W-1:0] cnt_eq_q;
    logic [CMP_CNT_W-1:0] cnt_gt_q;
    logic [CMP_CNT_W-1:0] cnt_lt_q;

    // Clear wins over an increment landing on the same edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_eq_q <= '0;
            cnt_gt_q <= '0;
            cnt_lt_q <= '0;
        end else if (stats_clear) begin
            cnt_eq_q <= '0;
            cnt_gt_q <= '0;
            cnt_lt_q <= '0;
        end else if (xfer_out) begin
            if (aEqualsB) begin
                cnt_eq_q <= sat_inc(cnt_eq_q);
            end
            if (aGreaterThanB) begin
                cnt_gt_q <= sat_inc(cnt_gt_q);
            end
            if (aLessThanB) begin
                cnt_lt_q <= sat_inc(cnt_lt_q);
            end
        end
    end

    assign cntEqual   = cnt_eq_q;
    assign cntGreater = cnt_gt_q;
    assign cntLess    = cnt_lt_q;
`else
    logic unused_stats;
    assign unused_stats = stats_clear ^ xfer_out;

    assign cntEqual   = '0;
    assign cntGreater = '0;
    assign cntLess    = '0;
`endif

endmodule
